// File: rtl/monitor_bus_pkg.sv
// monitor_bus_pkg: shared definitions for the monitor card bus (master and slave sides)
//   MON_ADDR_W / MON_DATA_W : bus address and data widths
//   MON_MAX_LEN             : longest burst a single command may request
//   mon_state_t             : master FSM state encoding
//   clip_len()              : maps a raw beat count onto 1..MON_MAX_LEN
package monitor_bus_pkg;
  localparam int MON_ADDR_W  = 10;
  localparam int MON_DATA_W  = 32;
  localparam int MON_MAX_LEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT_ACK,
    S_RELEASE,
    S_FINISH
  } mon_state_t;

  function automatic logic [5:0] clip_len(input logic [5:0] len);
    return (len == 6'd0) ? 6'd1 : (len > 6'(MON_MAX_LEN)) ? 6'(MON_MAX_LEN) : len;
  endfunction
endpackage

// File: rtl/ack_timer.sv
// ack_timer: acknowledge timeout counter for the bus master
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_clr            : zero the count
//   i_en             : count this cycle (master is waiting for an ack)
//   o_expire         : the current enabled cycle is the TIMEOUT-th wait cycle
module ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clr) r_cnt <= 8'd0;
    else if (i_en)           r_cnt <= r_cnt + 8'd1;
  end

  // count is zero in the first wait cycle, so the last permitted cycle sees TIMEOUT-1
  assign o_expire = i_en && (r_cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/monitor_master.sv
// monitor_master: card-bus initiator issuing single/burst reads and writes for the host
//   host side : i_req, i_req_wr, i_req_addr, i_req_len, i_req_wdata in;
//               o_busy, o_rvalid, o_rdata, o_wnext, o_done, o_err out
//   bus side  : o_card_sel, o_ai, o_wr_in_n, o_mdo out; i_sack_n, i_sdi in
//   i_clk, i_reset_n : clock, synchronous active-low reset
module monitor_master
  import monitor_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_req,
  input  logic                  i_req_wr,
  input  logic [MON_ADDR_W-1:0] i_req_addr,
  input  logic [5:0]            i_req_len,
  input  logic [MON_DATA_W-1:0] i_req_wdata,
  output logic                  o_busy,
  output logic                  o_rvalid,
  output logic [MON_DATA_W-1:0] o_rdata,
  output logic                  o_wnext,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_card_sel,
  output logic [MON_ADDR_W-1:0] o_ai,
  output logic                  o_wr_in_n,
  output logic [MON_DATA_W-1:0] o_mdo,
  input  logic                  i_sack_n,
  input  logic [MON_DATA_W-1:0] i_sdi
);
  mon_state_t            r_state, w_next;
  logic [5:0]            r_beats;
  logic [MON_ADDR_W-1:0] r_ai;
  logic [MON_DATA_W-1:0] r_mdo, r_rdata;
  logic                  r_wr_n, r_err, r_rvalid, r_wnext;
  logic                  w_expire, w_accept, w_ack, w_abort, w_rel_done;

  ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (r_state == S_SETUP),
    .i_en      (r_state == S_WAIT_ACK),
    .o_expire  (w_expire)
  );

  assign w_accept   = (r_state == S_IDLE) && i_req;
  assign w_ack      = (r_state == S_WAIT_ACK) && !i_sack_n;
  // an ack arriving on the expiry cycle still completes the beat
  assign w_abort    = (r_state == S_WAIT_ACK) && i_sack_n && w_expire;
  assign w_rel_done = (r_state == S_RELEASE) && i_sack_n;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = i_req ? S_SETUP : S_IDLE;
      S_SETUP:    w_next = S_WAIT_ACK;
      S_WAIT_ACK: w_next = w_ack ? S_RELEASE : w_abort ? S_FINISH : S_WAIT_ACK;
      S_RELEASE:  w_next = !w_rel_done ? S_RELEASE : (r_beats == 6'd1) ? S_FINISH : S_SETUP;
      S_FINISH:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_beats  <= 6'd0;
      r_ai     <= '0;
      r_mdo    <= '0;
      r_rdata  <= '0;
      r_wr_n   <= 1'b1;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
      r_wnext  <= 1'b0;
    end else begin
      r_rvalid <= w_ack && r_wr_n;
      r_wnext  <= w_ack && !r_wr_n;
      if (w_accept) begin
        r_ai    <= i_req_addr;
        r_wr_n  <= ~i_req_wr;
        r_beats <= clip_len(i_req_len);
        if (i_req_wr) r_mdo <= i_req_wdata;
      end
      if (w_ack && r_wr_n) r_rdata <= i_sdi;
      if (w_abort) r_err <= 1'b1;
      if (w_rel_done) begin
        r_beats <= r_beats - 6'd1;
        r_ai    <= r_ai + 1'b1;
        // next write word is taken as the following SETUP is entered
        if (!r_wr_n && r_beats != 6'd1) r_mdo <= i_req_wdata;
      end
      if (r_state == S_FINISH) begin
        r_err  <= 1'b0;
        r_wr_n <= 1'b1;
      end
    end
  end

  assign o_busy     = r_state != S_IDLE;
  assign o_card_sel = r_state == S_WAIT_ACK;
  assign o_done     = r_state == S_FINISH;
  assign o_err      = (r_state == S_FINISH) && r_err;
  assign o_rvalid   = r_rvalid;
  assign o_wnext    = r_wnext;
  assign o_rdata    = r_rdata;
  assign o_ai       = r_ai;
  assign o_wr_in_n  = r_wr_n;
  assign o_mdo      = r_mdo;
endmodule

// File: doc/monitor_master.md
# monitor_master

Bus initiator for the monitor card bus: it issues single and burst read/write transactions to slave cards through `CARD_SEL` / `AI` / `WR_IN_N` / `SACK_N` and returns read data to a host-side command port. It is the requesting end of the protocol that the monitor slave answers, and sits between the host controller and the card bus. Every transaction is bounded by an acknowledge timeout so that a missing card cannot hang the host.

## Interface
- `TIMEOUT`, default 255: max cycles in WAIT_ACK before abort; range 1..255.
- `CLK`  in  1  system clock; all logic rising-edge.
- `RESET_N`  in  1  synchronous active-low reset.
- `REQ`  in  1  host command strobe; sampled only in IDLE.
- `REQ_WR`  in  1  1 = write, 0 = read.
- `REQ_ADDR`  in  10  start address.
- `REQ_LEN`  in  6  beat count 1..32; 0 is treated as 1, values >32 are clipped to 32.
- `REQ_WDATA`  in  32  write data; sampled at each write beat's SETUP entry.
- `BUSY`  out  1  high from the cycle after acceptance until the return to IDLE.
- `RVALID`  out  1  one-cycle pulse per read beat.
- `RDATA`  out  32  captured read data; valid while `RVALID` is high.
- `WNEXT`  out  1  one-cycle pulse after each write beat is acknowledged; host presents the next word.
- `DONE`  out  1  one-cycle pulse at the end of a command.
- `ERR`  out  1  one-cycle pulse with `DONE` when the command aborted on timeout.
- `CARD_SEL`  out  1  bus select.
- `AI`  out  10  bus address.
- `WR_IN_N`  out  1  bus direction; 0 = write.
- `MDO`  out  32  bus write data.
- `SACK_N`  in  1  slave acknowledge, active low.
- `SDI`  in  32  slave read data (the slave's `SDO`).

## Operation
- States: IDLE, SETUP, WAIT_ACK, RELEASE, FINISH.
- IDLE: `REQ`=1 latches the command, loads the beat counter with the clipped length, and moves to SETUP.
- SETUP, 1 cycle:
  - drive `AI` = current address and `WR_IN_N` = ~wr;
  - drive `MDO` = `REQ_WDATA` on writes;
  - `CARD_SEL` stays 0 to give the slave one cycle of address setup;
  - move to WAIT_ACK.
- WAIT_ACK:
  - `CARD_SEL`=1; `AI`, `WR_IN_N` and `MDO` are held stable;
  - on `SACK_N`=0: read beats capture `SDI` into `RDATA` and pulse `RVALID` next cycle; write beats pulse `WNEXT` next cycle. Then move to RELEASE;
  - when the timeout counter reaches `TIMEOUT` with `SACK_N` still 1: go to FINISH with the error flag set and abandon the remaining beats.
- RELEASE:
  - `CARD_SEL`=0;
  - wait for `SACK_N`=1, which may already be 1 on entry;
  - then decrement the beat count and increment the address (mod 1024, so 1023 wraps to 0);
  - if beats remain, go to SETUP, otherwise go to FINISH.
  - No timeout applies in RELEASE.
- FINISH, 1 cycle: pulse `DONE`, plus `ERR` if the error flag is set. Return to IDLE and clear the flag.
- `REQ` outside IDLE is ignored; no queueing.
- Timeout counter: 8-bit, cleared on SETUP entry, increments each WAIT_ACK cycle.

## Timing
- Reset values: all outputs 0, except `WR_IN_N`=1. State goes to IDLE and all counters clear.
- Reset mid-transaction takes effect on the next edge: `CARD_SEL` drops immediately, and no `DONE` is issued.
- Acceptance to first `CARD_SEL` assertion: 2 cycles (IDLE→SETUP→WAIT_ACK).
- Minimum beat with immediate ack and release: SETUP + WAIT_ACK + RELEASE = 3 cycles, so a 32-beat read takes at least 96 cycles + FINISH.
- `RVALID` / `WNEXT` are asserted in the RELEASE entry cycle.
- `DONE` comes 1 cycle after the last RELEASE exit.
- If `SACK_N`=0 in the same cycle the timeout count is reached, the ack wins and the beat completes normally.

## Structure
- Shared package `monitor_bus_pkg`: state encoding constants, `MON_ADDR_W`=10, `MON_DATA_W`=32, `MON_MAX_LEN`=32.
- The same package is used by the slave side for address width.
- One natural sub-module: `ack_timer` (the timeout counter with clear / enable / expire outputs).
- Everything else stays in one flat FSM module.

## Test plan
- Single read at addr 0x021, slave acks after 3 cycles with `SDI`=0xDEADBEEF:
  - `RVALID` with `RDATA`=0xDEADBEEF;
  - `DONE`=1, `ERR`=0;
  - `AI` stable throughout WAIT_ACK.
- 4-beat write from addr 0x3FE with data 0x11/0x22/0x33/0x44:
  - bus sees `AI` = 0x3FE, 0x3FF, 0x000, 0x001 with matching `MDO`;
  - 4 `WNEXT` pulses, then `DONE`.
- No slave (`SACK_N` held 1), `TIMEOUT`=8:
  - `CARD_SEL` high for exactly 8 cycles;
  - `DONE`+`ERR` pulse, return to IDLE.
- Slave holds `SACK_N` low for 5 cycles after `CARD_SEL` drops:
  - master stays in RELEASE;
  - next SETUP begins only after `SACK_N`=1.
- `RESET_N`=0 during beat 2 of a 32-beat read:
  - next cycle all outputs are at reset values and no `DONE`;
  - a new `REQ` afterwards completes normally.
- `REQ_LEN`=0 and `REQ_LEN`=40: exactly 1 and 32 beats issued respectively.
